// File: rtl/div_pkg.sv
// Shared types for the iterative RV32M divider.
//   div_op_type  : one-hot operation select (div, divu, rem, remu)
//   div_in_type  : start request, flush, op select and the two operands
//   div_out_type : result word and one-cycle ready pulse
package div_pkg;

  typedef struct packed {
    logic div;
    logic divu;
    logic rem;
    logic remu;
  } div_op_type;

  typedef struct packed {
    logic        enable;
    logic        clear;
    div_op_type  div_op;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } div_in_type;

  typedef struct packed {
    logic [31:0] result;
    logic        ready;
  } div_out_type;

endpackage

// File: rtl/div_if.sv
// Execute-stage connection between the issue/operand-read stage and the
// divider.
//   div_in  : request bundle (enable, clear, div_op, rdata1, rdata2)
//   div_out : response bundle (result, ready)
//   master  : the pipeline side, drives div_in
//   slave   : the divider side, drives div_out
interface div_if;
  import div_pkg::*;

  div_in_type  div_in;
  div_out_type div_out;

  modport master (output div_in, input div_out);
  modport slave  (input div_in, output div_out);
endinterface

// File: rtl/div.sv
// Iterative radix-2 divider for RV32M DIV, DIVU, REM and REMU.
// One quotient bit per clock, followed by a sign-correction cycle.
// Divide-by-zero and signed overflow finish straight from IDLE.
//   clk : clock, all registers update on the rising edge
//   rst : synchronous active-high reset, also zeroes the result
//   bus : div_if slave port
//         div_in.enable : start request, honoured only in IDLE
//         div_in.clear  : flush, aborts any operation, keeps result
//         div_in.div_op : one-hot op select
//         div_in.rdata1 : dividend
//         div_in.rdata2 : divisor
//         div_out.result: quotient or remainder, held until next completion
//         div_out.ready : one-cycle completion pulse
module div
  import div_pkg::*;
#(
  parameter int XLEN = 32  // only 32 is supported
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  // Two's complement in XLEN bits: the magnitude of INT_MIN stays INT_MIN,
  // which is the correct value when read as unsigned.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic            is_signed);
    return (is_signed && v[XLEN-1]) ? -v : v;
  endfunction

  logic [1:0]      state;
  logic [4:0]      count;
  logic [XLEN-1:0] rem_q;      // partial remainder, always < divisor
  logic [XLEN-1:0] dq_q;       // dividend shifting out, quotient shifting in
  logic [XLEN-1:0] divisor_q;
  logic [XLEN-1:0] result_q;
  logic            q_sign;
  logic            r_sign;
  logic            quot_sel_q; // 1: div/divu return quotient, 0: rem/remu

  div_in_type in_d;
  assign in_d = bus.div_in;

  // Start decode. A request with no op bit set is not a valid start.
  logic            op_valid;
  logic            op_signed;
  logic            op_quot;
  logic            div_zero;
  logic            overflow;
  logic            s1;
  logic            s2;
  logic [XLEN-1:0] special_result;

  assign op_valid  = |in_d.div_op;
  assign op_signed = in_d.div_op.div | in_d.div_op.rem;
  assign op_quot   = in_d.div_op.div | in_d.div_op.divu;
  assign s1        = op_signed & in_d.rdata1[XLEN-1];
  assign s2        = op_signed & in_d.rdata2[XLEN-1];
  assign div_zero  = (in_d.rdata2 == '0);
  assign overflow  = op_signed && (in_d.rdata1 == INT_MIN) && (in_d.rdata2 == '1);

  assign special_result = div_zero ? (op_quot ? '1 : in_d.rdata1)
                                   : (op_quot ? INT_MIN : '0);

  // One restoring step. The working remainder is XLEN+1 bits wide so the
  // trial subtract cannot overflow; its top bit is the borrow.
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  assign shifted = {rem_q, dq_q[XLEN-1]};
  assign trial   = shifted - {1'b0, divisor_q};

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      rem_q      <= '0;
      dq_q       <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
      q_sign     <= 1'b0;
      r_sign     <= 1'b0;
      quot_sel_q <= 1'b0;
    end else if (in_d.clear) begin
      // Flush wins over everything; the last completed result stays visible.
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_d.enable && op_valid) begin
            quot_sel_q <= op_quot;
            if (div_zero || overflow) begin
              result_q <= special_result;
              state    <= DONE;
            end else begin
              rem_q     <= '0;
              dq_q      <= magnitude(in_d.rdata1, op_signed);
              divisor_q <= magnitude(in_d.rdata2, op_signed);
              q_sign    <= s1 ^ s2;
              r_sign    <= s1;
              count     <= '0;
              state     <= BUSY;
            end
          end
        end

        BUSY: begin
          if (!trial[XLEN]) begin
            rem_q <= trial[XLEN-1:0];
            dq_q  <= {dq_q[XLEN-2:0], 1'b1};
          end else begin
            rem_q <= shifted[XLEN-1:0];
            dq_q  <= {dq_q[XLEN-2:0], 1'b0};
          end
          count <= count + 5'd1;
          if (count == 5'd31) begin
            state <= FIX;
          end
        end

        FIX: begin
          if (quot_sel_q) begin
            result_q <= q_sign ? -dq_q : dq_q;
          end else begin
            result_q <= r_sign ? -rem_q : rem_q;
          end
          state <= DONE;
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.div_out = '{result: result_q, ready: (state == DONE)};

endmodule
